// File: rtl/ilog2_arbiter.sv
// rtl/ilog2_arbiter.sv - round-robin arbiter sharing one fixed-latency ilog2 pipeline among N_REQ lanes
// Optional per-lane grant and stall counters: ILOG2_ARB_STATS_EN
module ilog2_arbiter #(
  parameter int N_REQ    = 4,
  parameter int PIPE_LAT = 5,
  parameter int TAG_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_v,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [5*N_REQ-1:0]   rsp_log2,
  output logic [N_REQ-1:0]     rsp_zero,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy,
  output logic [31:0]          pipe_v,
  input  logic [4:0]           pipe_log2
`ifdef ILOG2_ARB_STATS_EN
  ,
  output logic [16*N_REQ-1:0]  stat_grant_cnt,
  output logic [15:0]          stat_stall_cnt
`endif
);

  // Head is one stage past PIPE_LAT so the result is sampled a cycle after it settles.
  localparam int H = PIPE_LAT + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   ptr;
  logic [TAG_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [31:0]        gnt_op;
  logic [H:0]         dl_vld;
  logic [H:0]         dl_zero;
  logic [TAG_W-1:0]   dl_tag [0:H];

  always_comb begin : p_grant
    int best;
    int d;
    best    = N_REQ;
    d       = 0;
    gnt_idx = '0;
    gnt_op  = '0;
    gnt_any = 1'b0;
    req_ready = '0;
    if (state == S_RUN && !flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i]) begin
          d = i - int'(ptr);
          if (d < 0) d = d + N_REQ;
          if (d < best) begin
            best    = d;
            gnt_idx = TAG_W'(i);
          end
        end
      end
      gnt_any = (best < N_REQ);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_any && gnt_idx == TAG_W'(i)) begin
        req_ready[i] = 1'b1;
        gnt_op       = req_v[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (flush) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!flush) state_nxt = S_RUN;
        else if (!busy && rsp_valid == '0) state_nxt = S_DONE;
      end
      S_DONE:  if (!flush) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  assign flush_done = (state == S_DONE);
  assign busy       = |dl_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_RUN;
      ptr    <= '0;
      pipe_v <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        ptr    <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        pipe_v <= gnt_op;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_vld  <= '0;
      dl_zero <= '0;
      for (int k = 0; k <= H; k++) dl_tag[k] <= '0;
    end else begin
      dl_vld  <= {dl_vld[H-1:0], gnt_any};
      dl_zero <= {dl_zero[H-1:0], (gnt_op == 32'd0)};
      dl_tag[0] <= gnt_idx;
      for (int k = 1; k <= H; k++) dl_tag[k] <= dl_tag[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_log2  <= '0;
      rsp_zero  <= '0;
    end else begin
      rsp_valid <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (dl_vld[H] && dl_tag[H] == TAG_W'(i)) begin
          rsp_valid[i]       <= 1'b1;
          rsp_log2[5*i +: 5] <= dl_zero[H] ? 5'd0 : pipe_log2;
          rsp_zero[i]        <= dl_zero[H];
        end
      end
    end
  end

`ifdef ILOG2_ARB_STATS_EN
  logic [15:0] grant_cnt [N_REQ];
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
    end else if (state == S_DONE) begin
      stall_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      if (|req_valid && !gnt_any && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && req_valid[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) stat_grant_cnt[16*i +: 16] = grant_cnt[i];
  end
  assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_ilog2_arbiter.sv
// tb/tb_ilog2_arbiter.sv - table, directed and random checks of ilog2_arbiter against a queue-based model
module tb_ilog2_arbiter;

  localparam int N = 4;
  localparam int LAT = 5;
  localparam int RSP_DLY = LAT + 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [32*N-1:0] req_v = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [5*N-1:0] rsp_log2;
  logic [N-1:0]   rsp_zero;
  logic           flush = 1'b0;
  logic           flush_done;
  logic           busy;
  logic [31:0]    pipe_v;
  logic [4:0]     pipe_log2;
`ifdef ILOG2_ARB_STATS_EN
  logic [16*N-1:0] stat_grant_cnt;
  logic [15:0]     stat_stall_cnt;
`endif

  ilog2_arbiter #(.N_REQ(N), .PIPE_LAT(LAT), .TAG_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_v(req_v), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_log2(rsp_log2), .rsp_zero(rsp_zero),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .pipe_v(pipe_v), .pipe_log2(pipe_log2)
`ifdef ILOG2_ARB_STATS_EN
    , .stat_grant_cnt(stat_grant_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ilog2(input logic [31:0] x);
    logic [4:0] r;
    r = 5'd0;
    for (int b = 0; b < 32; b++) if (x[b]) r = 5'(b);
    return r;
  endfunction

  // Shared pipeline stand-in; returns garbage for 0 so the DUT's zero forcing is visible.
  logic [31:0] hist [0:LAT];
  always @(posedge clk) begin
    hist[0] <= pipe_v;
    for (int k = 1; k <= LAT; k++) hist[k] <= hist[k-1];
  end
  assign pipe_log2 = (hist[LAT] == 32'd0) ? 5'd31 : ilog2(hist[LAT]);

  typedef struct {
    int         lane;
    logic [4:0] log2;
    logic       zero;
    int         due;
  } exp_t;

  typedef struct {
    logic [N-1:0] rv;
    logic [31:0]  op;
    logic [N-1:0] ready;
    logic [4:0]   log2;
    logic         zero;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ptr_m = 0;
  logic prev_fl = 1'b0;
  logic done_m = 1'b0;
  logic strobe_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] rv, input logic fl);
    logic [N-1:0] g;
    g = '0;
    if (!fl && !prev_fl) begin
      for (int k = 0; k < N; k++) begin
        if (g == '0 && rv[(ptr_m + k) % N]) g[(ptr_m + k) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  // Called at a falling edge; returns at the next falling edge with all outputs checked.
  task automatic run_cycle(input logic [N-1:0] rv, input logic [32*N-1:0] v, input logic fl,
                           input logic use_tbl, input logic [N-1:0] t_ready,
                           input logic [4:0] t_log2, input logic t_zero);
    logic [N-1:0] g;
    logic [N-1:0] emask;
    logic [31:0]  op;
    logic         drained;
    int           lane;
    exp_t         e;
    req_valid = rv;
    req_v     = v;
    flush     = fl;
    #1;
    g = model_grant(rv, fl);
    if (use_tbl) chk("tbl_ready", 32'(req_ready), 32'(t_ready));
    else         chk("req_ready", 32'(req_ready), 32'(g));
    lane = -1;
    for (int i = 0; i < N; i++) if (g[i]) lane = i;
    drained = (q.size() == 0) && !strobe_m;
    op = '0;
    if (lane >= 0) op = v[32*lane +: 32];
    @(posedge clk);
    cyc++;
    done_m  = fl && prev_fl && drained;
    prev_fl = fl;
    if (lane >= 0) begin
      ptr_m  = (lane + 1) % N;
      e.lane = lane;
      e.log2 = use_tbl ? t_log2 : ((op == 32'd0) ? 5'd0 : ilog2(op));
      e.zero = use_tbl ? t_zero : (op == 32'd0);
      e.due  = cyc + RSP_DLY;
      q.push_back(e);
    end
    @(negedge clk);
    if (lane >= 0) chk("pipe_v", pipe_v, op);
    emask = '0;
    for (int j = 0; j < q.size(); j++) if (q[j].due == cyc) emask[q[j].lane] = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 32'(emask));
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j].due == cyc) begin
        chk("rsp_log2", 32'(rsp_log2[5*q[j].lane +: 5]), 32'(q[j].log2));
        chk("rsp_zero", 32'(rsp_zero[q[j].lane]), 32'(q[j].zero));
        q.delete(j);
      end
    end
    strobe_m = (emask != '0);
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("flush_done", 32'(flush_done), 32'(done_m));
  endtask

  task automatic idle(input int n, input logic fl);
    for (int i = 0; i < n; i++) run_cycle('0, '0, fl, 1'b0, '0, 5'd0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return 32'd0;
    return $urandom >> $urandom_range(0, 31);
  endfunction

  task automatic rnd_cycle(input logic [N-1:0] rv, input logic fl);
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = rnd_op();
    run_cycle(rv, v, fl, 1'b0, '0, 5'd0, 1'b0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b0000, 32'h0000_0000, 4'b0000, 5'd0,  1'b0};
    tbl[1] = '{4'b0100, 32'h0000_0100, 4'b0100, 5'd8,  1'b0};
    tbl[2] = '{4'b1111, 32'h0000_0000, 4'b1000, 5'd0,  1'b1};
    tbl[3] = '{4'b1111, 32'h0000_0001, 4'b0001, 5'd0,  1'b0};
    tbl[4] = '{4'b0001, 32'hFFFF_FFFF, 4'b0001, 5'd31, 1'b0};
    tbl[5] = '{4'b0110, 32'h0000_0000, 4'b0010, 5'd0,  1'b1};
    tbl[6] = '{4'b0101, 32'h0000_0003, 4'b0100, 5'd1,  1'b0};
    tbl[7] = '{4'b0011, 32'h8000_0000, 4'b0001, 5'd31, 1'b0};
    tbl[8] = '{4'b1000, 32'h0001_2345, 4'b1000, 5'd16, 1'b0};

    // Reset state with idle inputs
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_log2", 32'(rsp_log2), 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pipe_v", pipe_v, 32'd0);
    reset = 1'b1;
    idle(2, 1'b0);

    foreach (tbl[i]) run_cycle(tbl[i].rv, {N{tbl[i].op}}, 1'b0, 1'b1, tbl[i].ready, tbl[i].log2, tbl[i].zero);
    idle(RSP_DLY + 2, 1'b0);

    // All lanes valid: strict rotation, in-order returns
    for (int i = 0; i < 8; i++) rnd_cycle('1, 1'b0);
    // Single lane repeatedly
    for (int i = 0; i < 5; i++) rnd_cycle(4'b0010, 1'b0);
    idle(RSP_DLY + 2, 1'b0);

    // Flush with three requests in flight; requests arrive with flush
    for (int i = 0; i < 3; i++) rnd_cycle(4'b0001 << i, 1'b0);
    for (int i = 0; i < 14; i++) rnd_cycle('1, 1'b1);
    chk("flush_done_held", 32'(flush_done), 32'd1);
    for (int i = 0; i < 3; i++) rnd_cycle('1, 1'b0);
    idle(RSP_DLY + 2, 1'b0);

    // Flush dropped while still draining
    for (int i = 0; i < 3; i++) rnd_cycle('1, 1'b0);
    for (int i = 0; i < 2; i++) rnd_cycle('1, 1'b1);
    for (int i = 0; i < 3; i++) rnd_cycle('1, 1'b0);
    idle(RSP_DLY + 2, 1'b0);

    // Reset with two requests in flight: dropped, pointer back to lane 0
    rnd_cycle(4'b0100, 1'b0);
    rnd_cycle(4'b1000, 1'b0);
    reset = 1'b0;
    q.delete();
    ptr_m = 0; prev_fl = 1'b0; done_m = 1'b0; strobe_m = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    idle(RSP_DLY + 3, 1'b0);
    run_cycle('1, {N{32'h40}}, 1'b0, 1'b1, 4'b0001, 5'd6, 1'b0);
    idle(RSP_DLY + 2, 1'b0);

    // Random traffic with occasional flush bursts
    for (int i = 0; i < 400; i++) begin
      logic fl;
      fl = ($urandom_range(0, 9) == 0) || (prev_fl && $urandom_range(0, 3) != 0);
      rnd_cycle(N'($urandom), fl);
    end
    idle(RSP_DLY + 2, 1'b0);
    chk("end_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
